// File: rtl/instruction_memory_pipelined.sv
// instruction_memory_pipelined: run-time loadable instruction store with wait-stated fetch handshake, freeze hold and fault flag
module instruction_memory_pipelined #(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 1,
    parameter int IDX_W       = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [31:0]      address,
    input  logic             freeze,
    output logic             ready,
    output logic             valid,
    output logic [31:0]      instruction,
    output logic             fault,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t      r_state, w_next;
    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_addr, r_instr, w_addr;
    logic [2:0]  r_cnt;
    logic        r_valid, r_fault, w_take, w_enter, w_fault;
    assign ready       = (r_state == IDLE) || (r_state == DONE && !freeze);
    assign valid       = r_valid;
    assign fault       = r_fault;
    assign instruction = r_instr;
    assign w_take      = req && ready;
    assign w_addr      = (r_state == BUSY) ? r_addr : address;
    assign w_fault     = (w_addr[1:0] != 2'b00) || ({2'b00, w_addr[31:2]} >= 32'(DEPTH));
    assign w_enter     = (w_take && WAIT_STATES == 0) || (r_state == BUSY && r_cnt == 3'd1);
    // next state: an accept restarts a fetch, BUSY counts down, a frozen DONE holds
    always_comb begin
        w_next = w_take ? ((WAIT_STATES == 0) ? DONE : BUSY) :
                 (r_state == BUSY) ? ((r_cnt == 3'd1) ? DONE : BUSY) :
                 (r_state == DONE && freeze) ? DONE : IDLE;
    end
    // load port; out-of-range indices and writes during reset are dropped
    always_ff @(posedge clk) begin
        if (wr_en && !rst && 32'(wr_idx) < 32'(DEPTH)) r_mem[wr_idx] <= wr_data;
    end
    // fetch FSM; data is sampled from the array before any same-edge write lands
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
            r_addr  <= 32'd0;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
            r_instr <= 32'd0;
        end else begin
            r_state <= w_next;
            r_valid <= (w_next == DONE);
            if (w_take) begin
                r_addr <= address;
                r_cnt  <= 3'(WAIT_STATES);
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt - 3'd1;
            end
            if (w_enter) begin
                r_fault <= w_fault;
                r_instr <= w_fault ? 32'd0 : r_mem[w_addr[IDX_W+1:2]];
            end else if (w_next != DONE) begin
                r_fault <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_instruction_memory_pipelined.sv
// tb_instruction_memory_pipelined: directed vector checks of the instruction store in three configurations
module tb_instruction_memory_pipelined;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_req = 0, a_frz = 0, a_we = 0, a_rdy, a_vld, a_flt;
    logic [31:0] a_addr = 0, a_wdat = 0, a_ins;
    logic [5:0]  a_widx = 0;
    logic        b_req = 0, b_frz = 0, b_we = 0, b_rdy, b_vld, b_flt;
    logic [31:0] b_addr = 0, b_wdat = 0, b_ins;
    logic [5:0]  b_widx = 0;
    logic        c_req = 0, c_frz = 0, c_we = 0, c_rdy, c_vld, c_flt;
    logic [31:0] c_addr = 0, c_wdat = 0, c_ins;
    logic [2:0]  c_widx = 0;

    instruction_memory_pipelined #(.DEPTH(64), .WAIT_STATES(0), .IDX_W(6)) u_a (
        .clk(clk), .rst(rst), .req(a_req), .address(a_addr), .freeze(a_frz), .ready(a_rdy), .valid(a_vld),
        .instruction(a_ins), .fault(a_flt), .wr_en(a_we), .wr_idx(a_widx), .wr_data(a_wdat));
    instruction_memory_pipelined #(.DEPTH(64), .WAIT_STATES(3), .IDX_W(6)) u_b (
        .clk(clk), .rst(rst), .req(b_req), .address(b_addr), .freeze(b_frz), .ready(b_rdy), .valid(b_vld),
        .instruction(b_ins), .fault(b_flt), .wr_en(b_we), .wr_idx(b_widx), .wr_data(b_wdat));
    instruction_memory_pipelined #(.DEPTH(5), .WAIT_STATES(1), .IDX_W(3)) u_c (
        .clk(clk), .rst(rst), .req(c_req), .address(c_addr), .freeze(c_frz), .ready(c_rdy), .valid(c_vld),
        .instruction(c_ins), .fault(c_flt), .wr_en(c_we), .wr_idx(c_widx), .wr_data(c_wdat));

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        frz;
        logic        we;
        logic [5:0]  widx;
        logic [31:0] wdat;
        logic        rdy;
        logic        vld;
        logic        flt;
        logic [31:0] ins;
    } vec_t;
    vec_t tv [16];
    int checks = 0, errors = 0, lat;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", n, act, exp);
        end
    endtask

    task automatic chk1(input string n, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%b exp=%b", n, act, exp);
        end
    endtask

    task automatic edge1;
        @(posedge clk);
        #1;
    endtask

    task automatic b_wait(output int l);
        l = 1;
        while (!b_vld && l < 20) begin
            edge1();
            l++;
        end
    endtask

    task automatic b_fetch(input logic [31:0] ad, output int l);
        b_req = 1; b_addr = ad;
        edge1();
        b_req = 0;
        b_wait(l);
    endtask

    task automatic c_fetch(input logic [31:0] ad, output int l);
        c_req = 1; c_addr = ad;
        edge1();
        c_req = 0;
        l = 1;
        while (!c_vld && l < 20) begin
            edge1();
            l++;
        end
    endtask

    task automatic b_write(input logic [5:0] i, input logic [31:0] d);
        b_we = 1; b_widx = i; b_wdat = d;
        edge1();
        b_we = 0;
    endtask

    task automatic c_write(input logic [2:0] i, input logic [31:0] d);
        c_we = 1; c_widx = i; c_wdat = d;
        edge1();
        c_we = 0;
    endtask

    initial begin
        tv[0]  = '{0, 32'h0,        0, 1, 6'd0,  32'hE3A00014, 1, 0, 0, 32'h0};
        tv[1]  = '{0, 32'h0,        0, 1, 6'd1,  32'hE3A01A01, 1, 0, 0, 32'h0};
        tv[2]  = '{0, 32'h0,        0, 1, 6'd63, 32'h12345678, 1, 0, 0, 32'h0};
        tv[3]  = '{0, 32'h0,        0, 1, 6'd2,  32'h11111111, 1, 0, 0, 32'h0};
        tv[4]  = '{1, 32'h0,        0, 0, 6'd0,  32'h0,        1, 1, 0, 32'hE3A00014};
        tv[5]  = '{1, 32'h4,        0, 0, 6'd0,  32'h0,        1, 1, 0, 32'hE3A01A01};
        tv[6]  = '{1, 32'h2,        0, 0, 6'd0,  32'h0,        1, 1, 1, 32'h0};
        tv[7]  = '{1, 32'h100,      0, 0, 6'd0,  32'h0,        1, 1, 1, 32'h0};
        tv[8]  = '{1, 32'h40000000, 0, 0, 6'd0,  32'h0,        1, 1, 1, 32'h0};
        tv[9]  = '{1, 32'hFC,       0, 0, 6'd0,  32'h0,        1, 1, 0, 32'h12345678};
        tv[10] = '{1, 32'h8,        0, 1, 6'd2,  32'hAAAAAAAA, 1, 1, 0, 32'h11111111};
        tv[11] = '{1, 32'h8,        0, 0, 6'd0,  32'h0,        1, 1, 0, 32'hAAAAAAAA};
        tv[12] = '{1, 32'h0,        1, 0, 6'd0,  32'h0,        0, 1, 0, 32'hAAAAAAAA};
        tv[13] = '{0, 32'h0,        1, 0, 6'd0,  32'h0,        0, 1, 0, 32'hAAAAAAAA};
        tv[14] = '{0, 32'h0,        0, 0, 6'd0,  32'h0,        1, 0, 0, 32'h0};
        tv[15] = '{0, 32'h0,        0, 0, 6'd0,  32'h0,        1, 0, 0, 32'h0};

        // reset held with requests pending
        a_req = 1; b_req = 1; c_req = 1;
        repeat (2) begin
            edge1();
            chk1("rst_a_rdy", a_rdy, 1'b1); chk1("rst_a_vld", a_vld, 1'b0);
            chk1("rst_a_flt", a_flt, 1'b0); chk("rst_a_ins", a_ins, 32'h0);
            chk1("rst_b_rdy", b_rdy, 1'b1); chk1("rst_b_vld", b_vld, 1'b0);
            chk1("rst_b_flt", b_flt, 1'b0); chk("rst_b_ins", b_ins, 32'h0);
        end
        rst = 0; a_req = 0; b_req = 0; c_req = 0;
        repeat (2) begin
            edge1();
            chk1("idle_a_vld", a_vld, 1'b0);
            chk1("idle_b_vld", b_vld, 1'b0);
        end

        // WAIT_STATES=0 vector table
        for (int i = 0; i < 16; i++) begin
            a_req = tv[i].req; a_addr = tv[i].addr; a_frz = tv[i].frz;
            a_we = tv[i].we; a_widx = tv[i].widx; a_wdat = tv[i].wdat;
            #1;
            chk1($sformatf("a_rdy[%0d]", i), a_rdy, tv[i].rdy);
            edge1();
            chk1($sformatf("a_vld[%0d]", i), a_vld, tv[i].vld);
            chk1($sformatf("a_flt[%0d]", i), a_flt, tv[i].flt);
            if (tv[i].vld) chk($sformatf("a_ins[%0d]", i), a_ins, tv[i].ins);
        end
        a_req = 0; a_we = 0; a_frz = 0;

        // WAIT_STATES=3: latency, freeze hold, accept on release
        b_write(6'd0, 32'hE3A00014);
        b_write(6'd1, 32'hE3A01A01);
        b_fetch(32'h4, lat);
        chk("b_lat", lat, 4);
        chk("b_ins", b_ins, 32'hE3A01A01);
        b_frz = 1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk1("b_frz_rdy", b_rdy, 1'b0);
            edge1();
            chk1("b_frz_vld", b_vld, 1'b1);
            chk("b_frz_ins", b_ins, 32'hE3A01A01);
        end
        b_frz = 0; b_req = 1; b_addr = 32'h0;
        #1;
        chk1("b_rel_rdy", b_rdy, 1'b1);
        edge1();
        b_req = 0;
        chk1("b_rel_vld", b_vld, 1'b0);
        b_wait(lat);
        chk("b_rel_lat", lat, 4);
        chk("b_rel_ins", b_ins, 32'hE3A00014);
        edge1();

        // WAIT_STATES=3: reset while BUSY drops the fetch
        b_req = 1; b_addr = 32'h4;
        edge1();
        b_req = 0;
        edge1();
        rst = 1;
        edge1();
        rst = 0;
        chk1("b_mid_rdy", b_rdy, 1'b1);
        chk1("b_mid_vld", b_vld, 1'b0);
        for (int k = 0; k < 6; k++) begin
            edge1();
            chk1("b_drop_vld", b_vld, 1'b0);
        end
        b_fetch(32'h4, lat);
        chk("b_post_lat", lat, 4);
        chk("b_post_ins", b_ins, 32'hE3A01A01);
        chk1("b_post_flt", b_flt, 1'b0);

        // DEPTH=5, WAIT_STATES=1: out-of-range writes and fetches
        c_write(3'd0, 32'hC0C0C0C0);
        c_write(3'd4, 32'h44444444);
        c_write(3'd5, 32'hDEADBEEF);
        c_write(3'd7, 32'hBADBADBA);
        c_fetch(32'h10, lat);
        chk("c_lat", lat, 2);
        chk("c_ins4", c_ins, 32'h44444444);
        chk1("c_flt4", c_flt, 1'b0);
        edge1();
        c_fetch(32'h0, lat);
        chk("c_ins0", c_ins, 32'hC0C0C0C0);
        edge1();
        c_fetch(32'h14, lat);
        chk1("c_flt5", c_flt, 1'b1);
        chk("c_ins5", c_ins, 32'h0);
        edge1();
        c_fetch(32'h10, lat);
        chk("c_ins4b", c_ins, 32'h44444444);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
